// File: rtl/pocket_input_pkg.sv
// Shared types for the Pocket controller input path: calibration FSM states,
// the analog pad type code and a small unsigned distance helper.
package pocket_input_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        CHECK,
        DONE
    } cal_state_t;

    localparam logic [3:0] PAD_TYPE_ANALOG = 4'h3;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/stick_axis_stats.sv
// Running sum, minimum and maximum of one stick axis over a calibration attempt.
module stick_axis_stats #(
    parameter int LOG2_SAMPLES = 4
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      add,
    input  logic [7:0]                sample,
    output logic [8+LOG2_SAMPLES-1:0] sum,
    output logic [7:0]                min_val,
    output logic [7:0]                max_val
);

    localparam int ACC_W = 8 + LOG2_SAMPLES;

    // min starts high and max low so the first added sample sets both
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum     <= '0;
            min_val <= 8'hFF;
            max_val <= 8'h00;
        end else if (clear) begin
            sum     <= '0;
            min_val <= 8'hFF;
            max_val <= 8'h00;
        end else if (add) begin
            sum <= sum + ACC_W'(sample);
            if (sample < min_val) min_val <= sample;
            if (sample > max_val) max_val <= sample;
        end
    end

endmodule

// File: rtl/analog_stick_calibrator.sv
// Per-pad stick centre calibration: settle, average, validate and publish the
// centres of LX/LY/RX/RY, retrying and finally falling back to CENTER.
module analog_stick_calibrator
    import pocket_input_pkg::*;
#(
    parameter logic [7:0] CENTER         = 8'h80,
    parameter int         LOG2_SAMPLES   = 4,
    parameter int         SETTLE_SAMPLES = 8,
    parameter logic [7:0] MAX_SPREAD     = 8'h08,
    parameter logic [7:0] MAX_OFFSET     = 8'h20,
    parameter int         MAX_RETRIES    = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [3:0] pad_type,
    input  logic       sample_stb,
    input  logic [7:0] joy_lx,
    input  logic [7:0] joy_ly,
    input  logic [7:0] joy_rx,
    input  logic [7:0] joy_ry,
    input  logic       recal_req,
    output logic [7:0] center_lx,
    output logic [7:0] center_ly,
    output logic [7:0] center_rx,
    output logic [7:0] center_ry,
    output logic       cal_valid,
    output logic       cal_busy,
    output logic       cal_error
);

    localparam int ACC_W = 8 + LOG2_SAMPLES;
    localparam int SET_W = $clog2(SETTLE_SAMPLES + 1);
    localparam int RET_W = $clog2(MAX_RETRIES + 2);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_SAMPLES - 1);
    localparam logic [RET_W-1:0] RETRY_LIMIT = RET_W'(MAX_RETRIES);
    localparam logic [ACC_W:0]   ROUND_HALF  = (ACC_W + 1)'(1) << (LOG2_SAMPLES - 1);

    cal_state_t              state;
    logic [SET_W-1:0]        settle_cnt;
    logic [LOG2_SAMPLES-1:0] accum_cnt;
    logic [RET_W-1:0]        retries;
    logic [7:0]              center_q [4];

    logic [7:0]       joy [4];
    logic [ACC_W-1:0] axis_sum [4];
    logic [7:0]       axis_min [4];
    logic [7:0]       axis_max [4];
    logic [7:0]       mean [4];
    logic [ACC_W:0]   rounded;
    logic             attempt_pass;
    logic             pad_ok;
    logic             stats_clear;
    logic             stats_add;

    assign joy    = '{joy_lx, joy_ly, joy_rx, joy_ry};
    assign pad_ok = (pad_type == PAD_TYPE_ANALOG);

    // Stats are cleared on the final settle strobe so the first ACCUM strobe starts fresh
    assign stats_clear = pad_ok && (state == SETTLE) && sample_stb && (settle_cnt == SETTLE_LAST);
    assign stats_add   = pad_ok && (state == ACCUM) && sample_stb;

    for (genvar i = 0; i < 4; i++) begin : g_axis
        stick_axis_stats #(.LOG2_SAMPLES(LOG2_SAMPLES)) u_stats (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .clear   (stats_clear),
            .add     (stats_add),
            .sample  (joy[i]),
            .sum     (axis_sum[i]),
            .min_val (axis_min[i]),
            .max_val (axis_max[i])
        );
    end

    // Round-half-up mean per axis; the carry bit above 8 bits saturates to 0xFF
    always_comb begin
        attempt_pass = 1'b1;
        rounded      = '0;
        mean         = '{default: 8'h00};
        for (int i = 0; i < 4; i++) begin
            rounded = {1'b0, axis_sum[i]} + ROUND_HALF;
            mean[i] = rounded[ACC_W] ? 8'hFF : rounded[ACC_W-1:LOG2_SAMPLES];
            if ((axis_max[i] - axis_min[i]) > MAX_SPREAD) attempt_pass = 1'b0;
            if (abs_diff(mean[i], CENTER) > MAX_OFFSET)  attempt_pass = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            accum_cnt  <= '0;
            retries    <= '0;
            center_q   <= '{default: CENTER};
            cal_valid  <= 1'b0;
            cal_busy   <= 1'b0;
            cal_error  <= 1'b0;
        end else if (!pad_ok) begin
            state      <= IDLE;
            settle_cnt <= '0;
            accum_cnt  <= '0;
            retries    <= '0;
            center_q   <= '{default: CENTER};
            cal_valid  <= 1'b0;
            cal_busy   <= 1'b0;
            cal_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                    retries    <= '0;
                    cal_busy   <= 1'b1;
                end
                SETTLE: begin
                    if (sample_stb) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state     <= ACCUM;
                            accum_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (sample_stb) begin
                        if (accum_cnt == '1) state <= CHECK;
                        else accum_cnt <= accum_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (attempt_pass) begin
                        state     <= DONE;
                        center_q  <= mean;
                        cal_valid <= 1'b1;
                        cal_error <= 1'b0;
                        cal_busy  <= 1'b0;
                    end else if (retries < RETRY_LIMIT) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        retries    <= retries + 1'b1;
                    end else begin
                        state     <= DONE;
                        center_q  <= '{default: CENTER};
                        cal_valid <= 1'b1;
                        cal_error <= 1'b1;
                        cal_busy  <= 1'b0;
                    end
                end
                DONE: begin
                    if (recal_req) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        retries    <= '0;
                        cal_busy   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign center_lx = center_q[0];
    assign center_ly = center_q[1];
    assign center_rx = center_q[2];
    assign center_ry = center_q[3];

endmodule

// File: tb/tb_analog_stick_calibrator.sv
// Directed bench for analog_stick_calibrator: each task drives one scenario and
// checks the published centres and status flags against hand-computed values.
module tb_analog_stick_calibrator;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] pad_type = 4'h0;
    logic       sample_stb = 1'b0;
    logic [7:0] joy_lx = 8'h80;
    logic [7:0] joy_ly = 8'h80;
    logic [7:0] joy_rx = 8'h80;
    logic [7:0] joy_ry = 8'h80;
    logic       recal_req = 1'b0;
    logic [7:0] center_lx, center_ly, center_rx, center_ry;
    logic       cal_valid, cal_busy, cal_error;

    int n_checks = 0;
    int n_fail   = 0;

    analog_stick_calibrator dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .pad_type   (pad_type),
        .sample_stb (sample_stb),
        .joy_lx     (joy_lx),
        .joy_ly     (joy_ly),
        .joy_rx     (joy_rx),
        .joy_ry     (joy_ry),
        .recal_req  (recal_req),
        .center_lx  (center_lx),
        .center_ly  (center_ly),
        .center_rx  (center_rx),
        .center_ry  (center_ry),
        .cal_valid  (cal_valid),
        .cal_busy   (cal_busy),
        .cal_error  (cal_error)
    );

    always #5 clk_sys = ~clk_sys;

    // One strobe followed by nine idle cycles; called and returns on a falling edge
    task automatic apply_sample(input logic [7:0] lx, input logic [7:0] ly,
                                input logic [7:0] rx, input logic [7:0] ry);
        joy_lx = lx; joy_ly = ly; joy_rx = rx; joy_ry = ry;
        sample_stb = 1'b1;
        @(negedge clk_sys);
        sample_stb = 1'b0;
        repeat (9) @(negedge clk_sys);
    endtask

    task automatic pulse_recal();
        recal_req = 1'b1;
        @(negedge clk_sys);
        recal_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        n_checks++;
        if ({center_lx, center_ly, center_rx, center_ry} !== 32'h80808080) begin
            n_fail++;
            $display("[TB] FAIL reset_centres got %h want 80808080", {center_lx, center_ly, center_rx, center_ry});
        end
        n_checks++;
        if ({cal_valid, cal_busy, cal_error} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags got %b want 000", {cal_valid, cal_busy, cal_error});
        end
        reset_n = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic test_steady();
        pad_type = 4'h3;
        @(negedge clk_sys);
        n_checks++;
        if (cal_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL steady_busy_start got %b want 1", cal_busy);
        end
        repeat (24) apply_sample(8'h80, 8'h80, 8'h80, 8'h80);
        n_checks++;
        if ({center_lx, center_ly, center_rx, center_ry} !== 32'h80808080) begin
            n_fail++;
            $display("[TB] FAIL steady_centres got %h want 80808080", {center_lx, center_ly, center_rx, center_ry});
        end
        n_checks++;
        if ({cal_valid, cal_busy, cal_error} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL steady_flags got %b want 100", {cal_valid, cal_busy, cal_error});
        end
    endtask

    task automatic test_half_up();
        pulse_recal();
        repeat (8) apply_sample(8'h84, 8'h80, 8'h80, 8'h80);
        for (int i = 0; i < 16; i++)
            apply_sample((i % 2 == 0) ? 8'h84 : 8'h85, 8'h80, 8'h80, 8'h80);
        n_checks++;
        if ({center_lx, center_ly, center_rx, center_ry} !== 32'h85808080) begin
            n_fail++;
            $display("[TB] FAIL half_up_centres got %h want 85808080", {center_lx, center_ly, center_rx, center_ry});
        end
    endtask

    task automatic test_spread();
        pulse_recal();
        for (int a = 0; a < 3; a++) begin
            repeat (8) apply_sample(8'h80, 8'h80, 8'h80, 8'h75);
            for (int i = 0; i < 16; i++)
                apply_sample(8'h80, 8'h80, 8'h80, 8'h70 + 8'(i % 11));
            if (a == 0) begin
                n_checks++;
                if ({center_lx, cal_busy, cal_error} !== {8'h85, 2'b10}) begin
                    n_fail++;
                    $display("[TB] FAIL spread_retry got lx=%h busy=%b err=%b want lx=85 busy=1 err=0",
                             center_lx, cal_busy, cal_error);
                end
            end
        end
        n_checks++;
        if ({center_lx, center_ly, center_rx, center_ry} !== 32'h80808080) begin
            n_fail++;
            $display("[TB] FAIL spread_fallback_centres got %h want 80808080", {center_lx, center_ly, center_rx, center_ry});
        end
        n_checks++;
        if ({cal_valid, cal_busy, cal_error} !== 3'b101) begin
            n_fail++;
            $display("[TB] FAIL spread_fallback_flags got %b want 101", {cal_valid, cal_busy, cal_error});
        end
    endtask

    task automatic test_offset();
        pulse_recal();
        repeat (24) apply_sample(8'h80, 8'hA1, 8'h80, 8'h80);
        n_checks++;
        if ({center_ly, cal_busy} !== {8'h80, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL offset_over got ly=%h busy=%b want ly=80 busy=1", center_ly, cal_busy);
        end
        repeat (8) apply_sample(8'h80, 8'hA0, 8'h80, 8'h80);
        for (int i = 0; i < 16; i++)
            apply_sample(8'h80, 8'hA0, (i % 2 == 0) ? 8'h7C : 8'h84, 8'h80);
        n_checks++;
        if ({center_lx, center_ly, center_rx, center_ry} !== 32'h80A08080) begin
            n_fail++;
            $display("[TB] FAIL offset_edge_centres got %h want 80a08080", {center_lx, center_ly, center_rx, center_ry});
        end
        n_checks++;
        if ({cal_valid, cal_busy, cal_error} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL offset_edge_flags got %b want 100", {cal_valid, cal_busy, cal_error});
        end
    endtask

    task automatic test_pad_drop();
        pulse_recal();
        repeat (13) apply_sample(8'h80, 8'h80, 8'h80, 8'h80);
        pad_type = 4'h0;
        sample_stb = 1'b1;
        @(negedge clk_sys);
        sample_stb = 1'b0;
        n_checks++;
        if ({center_lx, center_ly, center_rx, center_ry} !== 32'h80808080) begin
            n_fail++;
            $display("[TB] FAIL pad_drop_centres got %h want 80808080", {center_lx, center_ly, center_rx, center_ry});
        end
        n_checks++;
        if ({cal_valid, cal_busy, cal_error} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL pad_drop_flags got %b want 000", {cal_valid, cal_busy, cal_error});
        end
        repeat (3) @(negedge clk_sys);
        pad_type = 4'h3;
        @(negedge clk_sys);
        n_checks++;
        if (cal_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pad_return_busy got %b want 1", cal_busy);
        end
        repeat (24) apply_sample(8'h88, 8'h80, 8'h80, 8'h80);
        n_checks++;
        if ({center_lx, cal_valid, cal_busy, cal_error} !== {8'h88, 3'b100}) begin
            n_fail++;
            $display("[TB] FAIL pad_return_cal got lx=%h flags=%b want lx=88 flags=100",
                     center_lx, {cal_valid, cal_busy, cal_error});
        end
    endtask

    task automatic test_recal();
        pulse_recal();
        n_checks++;
        if ({center_lx, cal_valid, cal_busy} !== {8'h88, 2'b11}) begin
            n_fail++;
            $display("[TB] FAIL recal_hold got lx=%h valid=%b busy=%b want lx=88 valid=1 busy=1",
                     center_lx, cal_valid, cal_busy);
        end
        repeat (11) apply_sample(8'h90, 8'h80, 8'h80, 8'h80);
        pulse_recal();
        repeat (13) apply_sample(8'h90, 8'h80, 8'h80, 8'h80);
        n_checks++;
        if ({center_lx, cal_valid, cal_busy, cal_error} !== {8'h90, 3'b100}) begin
            n_fail++;
            $display("[TB] FAIL recal_result got lx=%h flags=%b want lx=90 flags=100",
                     center_lx, {cal_valid, cal_busy, cal_error});
        end
    endtask

    task automatic test_async_reset();
        pulse_recal();
        repeat (12) apply_sample(8'h90, 8'h80, 8'h80, 8'h80);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({center_lx, center_ly, center_rx, center_ry} !== 32'h80808080) begin
            n_fail++;
            $display("[TB] FAIL async_reset_centres got %h want 80808080", {center_lx, center_ly, center_rx, center_ry});
        end
        n_checks++;
        if ({cal_valid, cal_busy, cal_error} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL async_reset_flags got %b want 000", {cal_valid, cal_busy, cal_error});
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
    endtask

    initial begin
        test_reset();
        test_steady();
        test_half_up();
        test_spread();
        test_offset();
        test_pad_drop();
        test_recal();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
